// File: rtl/corr_pkg.sv
// Shared constants, state encoding and score-width helper for the correlation engine.
package corr_pkg;
    localparam int PIX_W_DEF    = 10;
    localparam int SEARCH_H_RES = 640;
    localparam int SEARCH_V_RES = 480;
    localparam int COORD_W      = 13;

    localparam int MODE_SIM = 0;
    localparam int MODE_SAD = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } corr_state_e;

    // Wide enough that WIN_H*WIN_V full-scale terms can never wrap.
    function automatic int corr_score_w(input int pix_w, input int win_h, input int win_v);
        return pix_w + $clog2(win_h * win_v);
    endfunction
endpackage

// File: rtl/corr_pix_term.sv
// Per-pixel correlation term: |a-b| (SAD) or full-scale minus |a-b| (similarity).
module corr_pix_term
    import corr_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int MODE  = MODE_SIM
) (
    input  logic [PIX_W-1:0] pix_a,
    input  logic [PIX_W-1:0] pix_b,
    output logic [PIX_W-1:0] term
);
    logic [PIX_W-1:0] diff;

    always_comb begin
        diff = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);
        term = (MODE == MODE_SAD) ? diff : ({PIX_W{1'b1}} - diff);
    end
endmodule

// File: rtl/corr_score_engine.sv
// Raster-scans a WIN_H x WIN_V window, accumulates per-pixel terms of latency-delayed
// readings and reports the final correlation score with a one-cycle done pulse.
module corr_score_engine
    import corr_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int WIN_H  = SEARCH_H_RES,
    parameter int WIN_V  = SEARCH_V_RES,
    parameter int RD_LAT = 2,
    parameter int MODE   = MODE_SIM,
    localparam int SCORE_W = corr_score_w(PIX_W, WIN_H, WIN_V)
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    input  logic               iStall,
    input  logic [COORD_W-1:0] iXstart,
    input  logic [COORD_W-1:0] iYstart,
    input  logic [PIX_W-1:0]   iRd_sram,
    input  logic [PIX_W-1:0]   iRd_search,
    output logic [COORD_W-1:0] oX_sram,
    output logic [COORD_W-1:0] oY_sram,
    output logic [COORD_W-1:0] oX_search,
    output logic [COORD_W-1:0] oY_search,
    output logic               oBusy,
    output logic               oDone,
    output logic [SCORE_W-1:0] oScore
);
    corr_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xorg_q, xorg_d, yorg_q, yorg_d;
    logic [SCORE_W-1:0] acc_q, acc_d, score_q, score_d;
    logic [SCORE_W-1:0] acc_sum;
    logic [PIX_W-1:0]   term;
    logic               issue, accum, tag_out, final_rd, last_coord;

    corr_pix_term #(.PIX_W(PIX_W), .MODE(MODE)) u_term (
        .pix_a (iRd_sram),
        .pix_b (iRd_search),
        .term  (term)
    );

    assign issue      = (state_q == ST_RUN) && !iStall;
    assign accum      = tag_out && !iStall;
    assign last_coord = (x_q == COORD_W'(WIN_H - 1)) && (y_q == COORD_W'(WIN_V - 1));
    assign acc_sum    = acc_q + SCORE_W'(term);

    // final_rd marks the reading that closes the window: with no read latency it is the
    // last coordinate itself, otherwise the only tag left in flight while draining.
    if (RD_LAT == 0) begin : g_nolat
        assign tag_out  = issue;
        assign final_rd = last_coord;
    end else begin : g_lat
        localparam logic [RD_LAT-1:0] REST_MASK = {RD_LAT{1'b1}} >> 1;
        logic [RD_LAT-1:0] tag_q, tag_d;

        always_comb begin
            tag_d = tag_q;
            if (!iStall) tag_d = (tag_q << 1) | RD_LAT'(issue);
        end

        always_ff @(posedge iCLK or posedge iRST) begin
            if (iRST) tag_q <= '0;
            else      tag_q <= tag_d;
        end

        assign tag_out  = tag_q[RD_LAT-1];
        assign final_rd = (state_q == ST_DRAIN) && ((tag_q & REST_MASK) == '0);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xorg_d  = xorg_q;
        yorg_d  = yorg_q;
        acc_d   = accum ? acc_sum : acc_q;
        score_d = score_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (iStart) begin
                    state_d = ST_RUN;
                    xorg_d  = iXstart;
                    yorg_d  = iYstart;
                    x_d     = '0;
                    y_d     = '0;
                    acc_d   = '0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (issue) begin
                    if (last_coord) begin
                        state_d = ST_DRAIN;
                    end else if (x_q == COORD_W'(WIN_H - 1)) begin
                        x_d = '0;
                        y_d = y_q + COORD_W'(1);
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                end
                if (accum && final_rd) begin
                    state_d = ST_DONE;
                    score_d = acc_sum;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xorg_q  <= '0;
            yorg_q  <= '0;
            acc_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xorg_q  <= xorg_d;
            yorg_q  <= yorg_d;
            acc_q   <= acc_d;
            score_q <= score_d;
        end
    end

    assign oX_sram   = xorg_q + x_q;
    assign oY_sram   = yorg_q + y_q;
    assign oX_search = x_q;
    assign oY_search = y_q;
    assign oBusy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign oDone     = (state_q == ST_DONE);
    assign oScore    = score_q;
endmodule

// File: tb/tb_corr_score_engine.sv
// Directed bench for corr_score_engine: four configurations, a cycle-level window model
// for the main 4x2 instance and hand-computed literal scores and latencies.
module tb_corr_score_engine;
    localparam int AH = 4, AV = 2, ARL = 2, AN = AH * AV;

    int n_chk = 0;
    int n_fail = 0;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    // instance A: 4x2, RD_LAT 2, similarity
    logic        st_a = 1'b0, stall_a = 1'b0;
    logic [12:0] xs_a = '0, ys_a = '0;
    logic [9:0]  rs_a, rq_a;
    logic [12:0] oxs_a, oys_a, oxq_a, oyq_a;
    logic        busy_a, done_a;
    logic [12:0] score_a;
    int          img_sel_a = 0;

    // instance B: 4x2, RD_LAT 2, SAD
    logic        st_b = 1'b0, stall_b = 1'b0;
    logic [9:0]  rs_b = '0, rq_b = '0;
    logic [12:0] oxs_b, oys_b, oxq_b, oyq_b;
    logic        busy_b, done_b;
    logic [12:0] score_b;

    // instance C: 1x1, RD_LAT 0, similarity
    logic        st_c = 1'b0, stall_c = 1'b0;
    logic [9:0]  rs_c = '0, rq_c = '0;
    logic [12:0] oxs_c, oys_c, oxq_c, oyq_c;
    logic        busy_c, done_c;
    logic [9:0]  score_c;

    // instance D: 64x48, RD_LAT 1, SAD
    logic        st_d = 1'b0, stall_d = 1'b0;
    logic [9:0]  rs_d = '0, rq_d = '0;
    logic [12:0] oxs_d, oys_d, oxq_d, oyq_d;
    logic        busy_d, done_d;
    logic [21:0] score_d;

    logic [12:0] zero13 = '0;

    corr_score_engine #(.PIX_W(10), .WIN_H(AH), .WIN_V(AV), .RD_LAT(ARL), .MODE(0)) dut_a (
        .iCLK(iCLK), .iRST(iRST), .iStart(st_a), .iStall(stall_a),
        .iXstart(xs_a), .iYstart(ys_a), .iRd_sram(rs_a), .iRd_search(rq_a),
        .oX_sram(oxs_a), .oY_sram(oys_a), .oX_search(oxq_a), .oY_search(oyq_a),
        .oBusy(busy_a), .oDone(done_a), .oScore(score_a));

    corr_score_engine #(.PIX_W(10), .WIN_H(4), .WIN_V(2), .RD_LAT(2), .MODE(1)) dut_b (
        .iCLK(iCLK), .iRST(iRST), .iStart(st_b), .iStall(stall_b),
        .iXstart(zero13), .iYstart(zero13), .iRd_sram(rs_b), .iRd_search(rq_b),
        .oX_sram(oxs_b), .oY_sram(oys_b), .oX_search(oxq_b), .oY_search(oyq_b),
        .oBusy(busy_b), .oDone(done_b), .oScore(score_b));

    corr_score_engine #(.PIX_W(10), .WIN_H(1), .WIN_V(1), .RD_LAT(0), .MODE(0)) dut_c (
        .iCLK(iCLK), .iRST(iRST), .iStart(st_c), .iStall(stall_c),
        .iXstart(zero13), .iYstart(zero13), .iRd_sram(rs_c), .iRd_search(rq_c),
        .oX_sram(oxs_c), .oY_sram(oys_c), .oX_search(oxq_c), .oY_search(oyq_c),
        .oBusy(busy_c), .oDone(done_c), .oScore(score_c));

    corr_score_engine #(.PIX_W(10), .WIN_H(64), .WIN_V(48), .RD_LAT(1), .MODE(1)) dut_d (
        .iCLK(iCLK), .iRST(iRST), .iStart(st_d), .iStall(stall_d),
        .iXstart(zero13), .iYstart(zero13), .iRd_sram(rs_d), .iRd_search(rq_d),
        .oX_sram(oxs_d), .oY_sram(oys_d), .oX_search(oxq_d), .oY_search(oyq_d),
        .oBusy(busy_d), .oDone(done_d), .oScore(score_d));

    function automatic int simg(input logic [12:0] x, input logic [12:0] y);
        return (int'(x) * 37 + int'(y) * 101 + 5) % 1024;
    endfunction

    function automatic int qimg(input int sel, input logic [12:0] x, input logic [12:0] y);
        if (sel == 0) return simg(x, y);
        return (int'(x) * 53 + int'(y) * 17 + 300) % 1024;
    endfunction

    // Expected window score straight from the definition: sum over the window of 1023-|a-b|.
    function automatic longint model_score(input logic [12:0] xo, input logic [12:0] yo, input int sel);
        longint s = 0;
        for (int y = 0; y < AV; y++) begin
            for (int x = 0; x < AH; x++) begin
                int a, b, d;
                a = simg(xo + 13'(x), yo + 13'(y));
                b = qimg(sel, 13'(x), 13'(y));
                d = (a > b) ? a - b : b - a;
                s += 1023 - d;
            end
        end
        return s;
    endfunction

    // Memory for A: returns the image at the coordinates issued ARL unstalled cycles ago.
    logic [12:0] dxs[2], dys[2], dxq[2], dyq[2];
    always @(posedge iCLK) begin
        if (!stall_a) begin
            dxs[0] <= oxs_a; dys[0] <= oys_a; dxq[0] <= oxq_a; dyq[0] <= oyq_a;
            dxs[1] <= dxs[0]; dys[1] <= dys[0]; dxq[1] <= dxq[0]; dyq[1] <= dyq[0];
        end
    end
    assign rs_a = 10'(simg(dxs[1], dys[1]));
    assign rq_a = 10'(qimg(img_sel_a, dxq[1], dyq[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Cycle model for A: coordinate index = unstalled cycles so far (clamped to the last),
    // done lands N+RD_LAT+1 cycles after start plus one per stall, score held between dones.
    bit          m_act = 0;
    int          m_t, m_u, m_st;
    logic [12:0] m_xo, m_yo;
    longint      m_exp, m_held = 0;

    initial forever begin
        @(negedge iCLK);
        if (iRST) begin
            m_act  = 0;
            m_held = 0;
            chk("a_rst_busy", 64'(busy_a), 0);
            chk("a_rst_done", 64'(done_a), 0);
            chk("a_rst_score", 64'(score_a), 0);
        end else begin
            bit fin;
            fin = 0;
            if (m_act) begin
                m_t++;
                if (m_t == AN + ARL + 1 + m_st) begin
                    fin = 1;
                end else begin
                    int idx;
                    logic [12:0] ex, ey;
                    idx = (m_u < AN) ? m_u : AN - 1;
                    ex  = 13'(idx % AH);
                    ey  = 13'(idx / AH);
                    chk("a_x_search", 64'(oxq_a), 64'(ex));
                    chk("a_y_search", 64'(oyq_a), 64'(ey));
                    chk("a_x_sram", 64'(oxs_a), 64'(13'(m_xo + ex)));
                    chk("a_y_sram", 64'(oys_a), 64'(13'(m_yo + ey)));
                    if (stall_a) m_st++;
                    else         m_u++;
                end
                chk("a_busy", 64'(busy_a), 64'(!fin));
                chk("a_done", 64'(done_a), 64'(fin));
                if (fin) begin
                    m_held = m_exp;
                    m_act  = 0;
                end
                chk("a_score", 64'(score_a), 64'(m_held));
            end else begin
                chk("a_idle_busy", 64'(busy_a), 0);
                chk("a_idle_done", 64'(done_a), 0);
                chk("a_idle_score", 64'(score_a), 64'(m_held));
            end
            if (!m_act && st_a) begin
                m_act = 1;
                m_t   = 0;
                m_u   = 0;
                m_st  = 0;
                m_xo  = xs_a;
                m_yo  = ys_a;
                m_exp = model_score(xs_a, ys_a, img_sel_a);
            end
        end
    end

    task automatic start_a(input logic [12:0] xo, input logic [12:0] yo, input logic stall0);
        @(posedge iCLK); #1;
        xs_a = xo; ys_a = yo; st_a = 1'b1; stall_a = stall0;
    endtask

    // Origin is scrambled in cycle 2 of every run; the latched value must not follow it.
    task automatic wait_a(input int st_from, input int st_len, input int restart_c,
                          output int lat, output longint sc);
        lat = -1;
        sc  = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge iCLK); #1;
            st_a    = (c == restart_c);
            stall_a = (c >= st_from) && (c < st_from + st_len);
            if (c == 2) begin
                xs_a ^= 13'h0155;
                ys_a ^= 13'h00aa;
            end
            @(negedge iCLK);
            if (done_a) begin
                lat = c;
                sc  = 64'(score_a);
                break;
            end
        end
        if (lat < 0) begin
            n_chk++; n_fail++;
            $display("FAIL a_timeout: got no oDone, expected one within 60 cycles");
        end
    endtask

    int     sel = 0;
    logic   done_m;
    logic [63:0] score_m;
    always_comb begin
        done_m  = 1'b0;
        score_m = '0;
        case (sel)
            1: begin done_m = done_b; score_m = 64'(score_b); end
            2: begin done_m = done_c; score_m = 64'(score_c); end
            3: begin done_m = done_d; score_m = 64'(score_d); end
            default: ;
        endcase
    end

    task automatic set_start(input int which, input logic v);
        st_b = (which == 1) ? v : 1'b0;
        st_c = (which == 2) ? v : 1'b0;
        st_d = (which == 3) ? v : 1'b0;
    endtask

    task automatic run_other(input int which, input int restart_c, input int bound,
                             output int lat, output longint sc);
        lat = -1;
        sc  = 0;
        sel = which;
        @(posedge iCLK); #1;
        set_start(which, 1'b1);
        for (int c = 1; c <= bound; c++) begin
            @(posedge iCLK); #1;
            set_start(which, c == restart_c);
            @(negedge iCLK);
            if (done_m) begin
                lat = c;
                sc  = score_m;
                break;
            end
        end
        set_start(which, 1'b0);
        if (lat < 0) begin
            n_chk++; n_fail++;
            $display("FAIL other_timeout: got no oDone on instance %0d, expected one within %0d cycles", which, bound);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1 ms");
        $fatal(1);
    end

    initial begin
        int     lat, n_done;
        longint sc;

        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b0;
        @(negedge iCLK);
        chk("post_rst_busy", 64'(busy_a), 0);
        chk("post_rst_score", 64'(score_a), 0);

        // identical images, origin 0: 8 * 1023
        img_sel_a = 0;
        start_a(13'd0, 13'd0, 1'b0);
        wait_a(0, 0, 0, lat, sc);
        chk("ident_lat", 64'(lat), 11);
        chk("ident_score", 64'(sc), 8184);

        // three stall cycles mid-run
        start_a(13'd0, 13'd0, 1'b0);
        wait_a(3, 3, 0, lat, sc);
        chk("stall_lat", 64'(lat), 14);
        chk("stall_score", 64'(sc), 8184);

        // varied images, stall together with start, start ignored in RUN
        img_sel_a = 1;
        start_a(13'd5, 13'd3, 1'b1);
        wait_a(0, 0, 2, lat, sc);
        chk("varied_lat", 64'(lat), 11);

        // restart from DONE, then a second run with one stall
        start_a(13'd2, 13'd1, 1'b0);
        wait_a(0, 0, 11, lat, sc);
        chk("b2b_lat1", 64'(lat), 11);
        wait_a(4, 1, 0, lat, sc);
        chk("b2b_lat2", 64'(lat), 12);

        // reset during DRAIN abandons the run
        img_sel_a = 0;
        start_a(13'd0, 13'd0, 1'b0);
        repeat (9) begin @(posedge iCLK); #1; st_a = 1'b0; end
        iRST = 1'b1;
        @(negedge iCLK);
        chk("drain_rst_busy", 64'(busy_a), 0);
        chk("drain_rst_score", 64'(score_a), 0);
        @(posedge iCLK); #1 iRST = 1'b0;
        n_done = 0;
        repeat (15) begin @(negedge iCLK); if (done_a) n_done++; end
        chk("drain_rst_no_done", 64'(n_done), 0);
        chk("drain_rst_busy_after", 64'(busy_a), 0);
        start_a(13'd0, 13'd0, 1'b0);
        wait_a(0, 0, 0, lat, sc);
        chk("restart_lat", 64'(lat), 11);
        chk("restart_score", 64'(sc), 8184);

        // SAD 100/40 over 8 pixels, both operand orders
        rs_b = 10'd100; rq_b = 10'd40;
        run_other(1, 0, 100, lat, sc);
        chk("sad_lat", 64'(lat), 11);
        chk("sad_score", 64'(sc), 480);
        rs_b = 10'd40; rq_b = 10'd100;
        run_other(1, 0, 100, lat, sc);
        chk("sad_swap_score", 64'(sc), 480);

        // 1x1 window, no read latency
        rs_c = 10'd500; rq_c = 10'd500;
        run_other(2, 0, 20, lat, sc);
        chk("w1_eq_lat", 64'(lat), 2);
        chk("w1_eq_score", 64'(sc), 1023);
        rs_c = 10'd0; rq_c = 10'd1023;
        run_other(2, 1, 20, lat, sc);
        chk("w1_ext_lat", 64'(lat), 2);
        chk("w1_ext_score", 64'(sc), 0);
        n_done = 0;
        repeat (5) begin @(negedge iCLK); if (done_c) n_done++; end
        chk("w1_ignored_start", 64'(n_done), 0);
        chk("w1_busy_after", 64'(busy_c), 0);

        // 64x48 full-scale SAD: 3072 * 1023
        rs_d = 10'd0; rq_d = 10'd1023;
        run_other(3, 0, 5000, lat, sc);
        chk("big_lat", 64'(lat), 3074);
        chk("big_score", 64'(sc), 3142656);

        repeat (2) @(posedge iCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
